// File: rtl/spike_addr_tx.sv
// Spike-address transmitter: captures a fired-neuron bitmap and streams BASE_ADDR+k for
// each set bit (lowest first) over a valid/ready handshake, then pulses clear.
module spike_addr_tx #(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(13),
  parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                   CLK_Tx,
  input  logic                   RST,
  input  logic [NUM_NEURONS-1:0] spike_vector,
  input  logic                   spike_load,
  output logic                   load_ready,
  output logic [ADDR_W-1:0]      source_address,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   clear,
  output logic                   busy,
  output logic                   overrun,
  output logic [6:0]             spike_count,
  output logic [15:0]            ts_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CLEAR} state_t;

  state_t                 r_state, w_state_nx;
  logic [NUM_NEURONS-1:0] r_pending, w_pending_nx, w_remaining;
  logic [ADDR_W-1:0]      r_addr, w_addr_nx;
  logic                   r_valid, w_valid_nx;
  logic                   r_clear, w_clear_nx;
  logic                   r_overrun, w_overrun_nx;
  logic                   r_load_ready, w_load_ready_nx;
  logic                   r_busy, w_busy_nx;
  logic [6:0]             r_spike_count, w_spike_count_nx;
  logic [15:0]            r_ts_count, w_ts_count_nx;

  // Address of the lowest set bit of v; IDLE_ADDR when v is empty.
  function automatic logic [ADDR_W-1:0] lowest_addr(input logic [NUM_NEURONS-1:0] v);
    logic [ADDR_W-1:0] a;
    a = IDLE_ADDR;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) a = ADDR_W'(BASE_ADDR + ADDR_W'(i));
    end
    return a;
  endfunction

  always_comb begin
    w_state_nx       = r_state;
    w_pending_nx     = r_pending;
    w_addr_nx        = IDLE_ADDR;
    w_valid_nx       = 1'b0;
    w_clear_nx       = 1'b0;
    w_overrun_nx     = 1'b0;
    w_spike_count_nx = r_spike_count;
    w_ts_count_nx    = r_ts_count;
    // Pending mask with its lowest set bit removed.
    w_remaining      = r_pending & (r_pending - NUM_NEURONS'(1));

    case (r_state)
      S_IDLE: begin
        if (spike_load) begin
          w_pending_nx     = spike_vector;
          w_spike_count_nx = 7'd0;
          if (spike_vector != '0) begin
            w_state_nx = S_SEND;
            w_valid_nx = 1'b1;
            w_addr_nx  = lowest_addr(spike_vector);
          end else begin
            w_state_nx = S_CLEAR;
            w_clear_nx = 1'b1;
          end
        end
      end
      S_SEND: begin
        w_overrun_nx = spike_load;
        if (addr_ready) begin
          w_pending_nx     = w_remaining;
          w_spike_count_nx = r_spike_count + 7'd1;
          if (w_remaining != '0) begin
            w_valid_nx = 1'b1;
            w_addr_nx  = lowest_addr(w_remaining);
          end else begin
            w_state_nx = S_CLEAR;
            w_clear_nx = 1'b1;
          end
        end else begin
          w_valid_nx = 1'b1;
          w_addr_nx  = r_addr;
        end
      end
      S_CLEAR: begin
        w_overrun_nx  = spike_load;
        w_ts_count_nx = r_ts_count + 16'd1;
        w_state_nx    = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_load_ready_nx = (w_state_nx == S_IDLE);
    w_busy_nx       = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge CLK_Tx) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_addr        <= IDLE_ADDR;
      r_valid       <= 1'b0;
      r_clear       <= 1'b0;
      r_overrun     <= 1'b0;
      r_load_ready  <= 1'b1;
      r_busy        <= 1'b0;
      r_spike_count <= 7'd0;
      r_ts_count    <= 16'd0;
    end else begin
      r_state       <= w_state_nx;
      r_pending     <= w_pending_nx;
      r_addr        <= w_addr_nx;
      r_valid       <= w_valid_nx;
      r_clear       <= w_clear_nx;
      r_overrun     <= w_overrun_nx;
      r_load_ready  <= w_load_ready_nx;
      r_busy        <= w_busy_nx;
      r_spike_count <= w_spike_count_nx;
      r_ts_count    <= w_ts_count_nx;
    end
  end

  assign load_ready     = r_load_ready;
  assign source_address = r_addr;
  assign addr_valid     = r_valid;
  assign clear          = r_clear;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign spike_count    = r_spike_count;
  assign ts_count       = r_ts_count;

endmodule

// File: tb/tb_spike_addr_tx.sv
// Directed bench for spike_addr_tx: each task drives one scenario and checks outputs
// sampled 1ns after the rising edge against hand-computed values.
module tb_spike_addr_tx;

  logic        CLK_Tx = 1'b0;
  logic        RST;
  logic [7:0]  spike_vector;
  logic        spike_load;
  logic        load_ready;
  logic [11:0] source_address;
  logic        addr_valid;
  logic        addr_ready;
  logic        clear;
  logic        busy;
  logic        overrun;
  logic [6:0]  spike_count;
  logic [15:0] ts_count;

  int total = 0;
  int bad   = 0;

  spike_addr_tx dut (
    .CLK_Tx         (CLK_Tx),
    .RST            (RST),
    .spike_vector   (spike_vector),
    .spike_load     (spike_load),
    .load_ready     (load_ready),
    .source_address (source_address),
    .addr_valid     (addr_valid),
    .addr_ready     (addr_ready),
    .clear          (clear),
    .busy           (busy),
    .overrun        (overrun),
    .spike_count    (spike_count),
    .ts_count       (ts_count)
  );

  always #5 CLK_Tx = ~CLK_Tx;

  task automatic tick();
    @(posedge CLK_Tx);
    #1;
  endtask

  // {load_ready, addr_valid, clear, busy, overrun}
  function automatic logic [4:0] flags();
    return {load_ready, addr_valid, clear, busy, overrun};
  endfunction

  task automatic test_reset();
    RST = 1'b1; spike_load = 1'b0; spike_vector = 8'h00; addr_ready = 1'b0;
    tick(); tick();
    RST = 1'b0;
    total++;
    if (flags() !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got=%b want=%b", flags(), 5'b10000);
    end
    total++;
    if ({source_address, spike_count, ts_count} !== {12'hFFF, 7'd0, 16'd0}) begin
      bad++; $display("FAIL reset_values addr=%h cnt=%0d ts=%0d want FFF/0/0",
                      source_address, spike_count, ts_count);
    end
  endtask

  task automatic test_full_rate();
    logic [11:0] exp_addr [3];
    exp_addr = '{12'd13, 12'd15, 12'd17};
    spike_vector = 8'b0001_0101; spike_load = 1'b1; addr_ready = 1'b1;
    tick();
    spike_load = 1'b0; spike_vector = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({addr_valid, source_address, clear} !== {1'b1, exp_addr[i], 1'b0}) begin
        bad++; $display("FAIL full_rate_addr%0d got v=%b a=%0d c=%b want v=1 a=%0d c=0",
                        i, addr_valid, source_address, clear, exp_addr[i]);
      end
      tick();
    end
    total++;
    if ({flags(), source_address, spike_count} !== {5'b00110, 12'hFFF, 7'd3}) begin
      bad++; $display("FAIL full_rate_clear flags=%b a=%h cnt=%0d want 00110/FFF/3",
                      flags(), source_address, spike_count);
    end
    tick();
    total++;
    if ({flags(), ts_count, spike_count} !== {5'b10000, 16'd1, 7'd3}) begin
      bad++; $display("FAIL full_rate_idle flags=%b ts=%0d cnt=%0d want 10000/1/3",
                      flags(), ts_count, spike_count);
    end
  endtask

  task automatic test_stall();
    spike_vector = 8'b1000_0001; spike_load = 1'b1; addr_ready = 1'b0;
    tick();
    spike_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({addr_valid, source_address} !== {1'b1, 12'd13}) begin
        bad++; $display("FAIL stall_hold%0d got v=%b a=%0d want v=1 a=13",
                        i, addr_valid, source_address);
      end
      if (i < 2) tick();
    end
    addr_ready = 1'b1;
    tick();
    total++;
    if ({addr_valid, source_address, spike_count} !== {1'b1, 12'd20, 7'd1}) begin
      bad++; $display("FAIL stall_second got v=%b a=%0d cnt=%0d want v=1 a=20 cnt=1",
                      addr_valid, source_address, spike_count);
    end
    tick();
    total++;
    if ({clear, addr_valid, spike_count} !== {1'b1, 1'b0, 7'd2}) begin
      bad++; $display("FAIL stall_clear got c=%b v=%b cnt=%0d want c=1 v=0 cnt=2",
                      clear, addr_valid, spike_count);
    end
    tick();
    total++;
    if (ts_count !== 16'd2) begin
      bad++; $display("FAIL stall_ts got=%0d want=2", ts_count);
    end
  endtask

  task automatic test_empty();
    spike_vector = 8'h00; spike_load = 1'b1; addr_ready = 1'b1;
    tick();
    spike_load = 1'b0;
    total++;
    if ({flags(), spike_count} !== {5'b00110, 7'd0}) begin
      bad++; $display("FAIL empty_clear flags=%b cnt=%0d want 00110/0", flags(), spike_count);
    end
    tick();
    total++;
    if ({flags(), ts_count} !== {5'b10000, 16'd3}) begin
      bad++; $display("FAIL empty_idle flags=%b ts=%0d want 10000/3", flags(), ts_count);
    end
  endtask

  task automatic test_overrun();
    spike_vector = 8'b0000_0110; spike_load = 1'b1; addr_ready = 1'b1;
    tick();
    total++;
    if ({addr_valid, source_address, overrun} !== {1'b1, 12'd14, 1'b0}) begin
      bad++; $display("FAIL ovr_first got v=%b a=%0d o=%b want v=1 a=14 o=0",
                      addr_valid, source_address, overrun);
    end
    spike_vector = 8'hFF;
    tick();
    spike_load = 1'b0;
    total++;
    if ({addr_valid, source_address, overrun} !== {1'b1, 12'd15, 1'b1}) begin
      bad++; $display("FAIL ovr_pulse got v=%b a=%0d o=%b want v=1 a=15 o=1",
                      addr_valid, source_address, overrun);
    end
    tick();
    total++;
    if ({clear, overrun, spike_count} !== {1'b1, 1'b0, 7'd2}) begin
      bad++; $display("FAIL ovr_clear got c=%b o=%b cnt=%0d want c=1 o=0 cnt=2",
                      clear, overrun, spike_count);
    end
    // A load during the clear cycle is refused and flagged.
    spike_vector = 8'h01; spike_load = 1'b1;
    tick();
    spike_load = 1'b0;
    total++;
    if ({flags(), ts_count} !== {5'b10001, 16'd4}) begin
      bad++; $display("FAIL ovr_in_clear flags=%b ts=%0d want 10001/4", flags(), ts_count);
    end
    tick();
    total++;
    if (flags() !== 5'b10000) begin
      bad++; $display("FAIL ovr_ignored flags=%b want 10000", flags());
    end
  endtask

  task automatic test_rst_mid_send();
    spike_vector = 8'b0000_0011; spike_load = 1'b1; addr_ready = 1'b0;
    tick();
    spike_load = 1'b0;
    total++;
    if ({addr_valid, source_address} !== {1'b1, 12'd13}) begin
      bad++; $display("FAIL rst_pre got v=%b a=%0d want v=1 a=13", addr_valid, source_address);
    end
    RST = 1'b1; addr_ready = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if ({flags(), source_address, ts_count} !== {5'b10000, 12'hFFF, 16'd0}) begin
      bad++; $display("FAIL rst_mid flags=%b a=%h ts=%0d want 10000/FFF/0",
                      flags(), source_address, ts_count);
    end
    tick();
    total++;
    if ({clear, addr_valid} !== 2'b00) begin
      bad++; $display("FAIL rst_no_clear got c=%b v=%b want 0 0", clear, addr_valid);
    end
  endtask

  task automatic test_ts_wrap();
    force dut.r_ts_count = 16'hFFFE;
    #1;
    release dut.r_ts_count;
    spike_vector = 8'h00; addr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      spike_load = 1'b1;
      tick();
      spike_load = 1'b0;
      tick();
      total++;
      if (ts_count !== (i == 0 ? 16'hFFFF : 16'h0000)) begin
        bad++; $display("FAIL ts_wrap%0d got=%h want=%h", i, ts_count,
                        (i == 0 ? 16'hFFFF : 16'h0000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_stall();
    test_empty();
    test_overrun();
    test_rst_mid_send();
    test_ts_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
